// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 512-bit block into a 16-word sliding window
// and streams W_0..W_{ROUNDS-1} to the compression stage with a valid/ready handshake.
module sha256_msg_schedule #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [511:0] blk_in,
    input  logic         blk_valid,
    output logic         blk_ready,
    output logic [31:0]  w_out,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [5:0]   w_round,
    output logic         w_last
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    state_t      state_q, state_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [5:0]  round_q, round_d;
    logic [31:0] next_word_s;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        sigma0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        sigma1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b00_0000_0000, x[31:10]};
    endfunction

    // W_{t+16} from the current window; 32-bit truncation discards carries
    assign next_word_s = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

    // Next-state, window shift and round counter
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        round_d = round_q;
        case (state_q)
            IDLE: begin
                if (blk_valid) begin
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = blk_in[32*(15-i) +: 32];
                    end
                    round_d = 6'd0;
                    state_d = RUN;
                end else begin
                    round_d = 6'd0;
                end
            end
            RUN: begin
                if (w_ready) begin
                    for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[15] = next_word_s;
                    if (round_q == LAST_ROUND) begin
                        round_d = 6'd0;
                        state_d = IDLE;
                    end else begin
                        round_d = round_q + 6'd1;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                round_d = 6'd0;
            end
        endcase
    end

    // State, window and round registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            round_q <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'h0000_0000;
            end
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    // Outputs decode directly from state so reset takes effect without a clock
    always_comb begin
        blk_ready = (state_q == IDLE);
        w_valid   = (state_q == RUN);
        if (state_q == RUN) begin
            w_out   = win_q[0];
            w_round = round_q;
            w_last  = (round_q == LAST_ROUND);
        end else begin
            w_out   = 32'h0000_0000;
            w_round = 6'd0;
            w_last  = 1'b0;
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Scoreboard bench for sha256_msg_schedule: software schedule model feeds an
// expected-word queue that is drained as the DUT completes handshakes.
module tb_sha256_msg_schedule;

    logic         clk;
    logic         rst_n;
    logic [511:0] blk_in;
    logic         blk_valid, blk_ready;
    logic [31:0]  w_out;
    logic         w_valid, w_ready, w_last;
    logic [5:0]   w_round;

    logic         blk_valid16, blk_ready16;
    logic [31:0]  w_out16;
    logic         w_valid16, w_ready16, w_last16;
    logic [5:0]   w_round16;

    int           n_cmp;
    int           n_err;
    logic [31:0]  sb_q [$];
    logic [31:0]  exp_w [64];
    logic [31:0]  obs_w [64];

    sha256_msg_schedule #(.ROUNDS(64)) dut (
        .clk(clk), .rst_n(rst_n), .blk_in(blk_in), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .w_out(w_out), .w_valid(w_valid),
        .w_ready(w_ready), .w_round(w_round), .w_last(w_last)
    );

    sha256_msg_schedule #(.ROUNDS(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .blk_in(blk_in), .blk_valid(blk_valid16),
        .blk_ready(blk_ready16), .w_out(w_out16), .w_valid(w_valid16),
        .w_ready(w_ready16), .w_round(w_round16), .w_last(w_last16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_s0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] m_s1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    task automatic build_sched(input logic [511:0] blk);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) exp_w[t] = blk[511-32*t -: 32];
            else exp_w[t] = m_s1(exp_w[t-2]) + exp_w[t-7] + m_s0(exp_w[t-15]) + exp_w[t-16];
        end
    endtask

    // Run one 64-word block; optional random stalls, a stray blk_valid pulse at t=5,
    // or blk_valid held high with next_blk presented throughout.
    task automatic run_block(input logic [511:0] blk, input bit stall, input bit pulse,
                             input bit hold, input logic [511:0] next_blk);
        int hs;
        int cyc;
        logic [31:0] cur_w;
        logic [5:0]  cur_r;
        logic        rdy;
        logic [31:0] exp;
        build_sched(blk);
        for (int t = 0; t < 64; t++) sb_q.push_back(exp_w[t]);
        check_val("idle_blk_ready", blk_ready, 1);
        blk_in    = blk;
        blk_valid = 1'b1;
        @(posedge clk); #1;
        blk_valid = hold;
        blk_in    = hold ? next_blk : ~blk;
        check_val("first_valid", w_valid, 1);
        hs  = 0;
        cyc = 0;
        while (hs < 64 && cyc < 1000) begin
            cyc++;
            cur_w = w_out;
            cur_r = w_round;
            check_val("w_valid", w_valid, 1);
            check_val("busy_blk_ready", blk_ready, 0);
            check_val("w_round", cur_r, hs);
            check_val("w_last", w_last, (hs == 63));
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            w_ready = rdy;
            if (pulse && hs == 5) begin
                blk_valid = 1'b1;
                blk_in    = {16{32'hDEAD_BEEF}};
            end else begin
                blk_valid = hold;
            end
            @(posedge clk); #1;
            if (rdy) begin
                exp = sb_q.pop_front();
                check_val("w_out", cur_w, exp);
                obs_w[hs] = cur_w;
                hs++;
            end else begin
                check_val("stall_w_out", w_out, sb_q[0]);
                check_val("stall_w_round", w_round, hs);
            end
        end
        w_ready = 1'b0;
        check_val("handshakes", hs, 64);
        check_val("done_blk_ready", blk_ready, 1);
        check_val("done_w_valid", w_valid, 0);
        check_val("done_w_out", w_out, 0);
        check_val("done_w_round", w_round, 0);
    endtask

    localparam logic [511:0] ABC_BLK = {32'h6162_6380, {14{32'h0000_0000}}, 32'h0000_0018};

    logic [511:0] rnd_blk, rnd_blk2;
    int           cyc;
    int           k;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        blk_in = '0;
        blk_valid = 1'b0;
        w_ready = 1'b0;
        blk_valid16 = 1'b0;
        w_ready16 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rnd_blk[32*i +: 32]  = $urandom;
            rnd_blk2[32*i +: 32] = $urandom;
        end
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_w_valid", w_valid, 0);
        check_val("rst_blk_ready", blk_ready, 1);
        check_val("rst_w_out", w_out, 0);
        check_val("rst_w_round", w_round, 0);
        check_val("rst_w_last", w_last, 0);
        rst_n = 1'b1;

        // Padded "abc" with w_ready held high
        run_block(ABC_BLK, 1'b0, 1'b0, 1'b0, '0);
        check_val("abc_W0", obs_w[0], 32'h6162_6380);
        check_val("abc_W15", obs_w[15], 32'h0000_0018);
        check_val("abc_W16", obs_w[16], 32'h6162_6380);
        check_val("abc_W17", obs_w[17], 32'h000F_0000);

        // Random block with random back-pressure
        run_block(rnd_blk, 1'b1, 1'b0, 1'b0, '0);

        // Stray blk_valid pulse mid-block
        run_block(rnd_blk2, 1'b0, 1'b1, 1'b0, '0);

        // Back-to-back blocks with blk_valid held high
        run_block(rnd_blk, 1'b0, 1'b0, 1'b1, rnd_blk2);
        run_block(rnd_blk2, 1'b0, 1'b0, 1'b0, '0);
        check_val("b2b_W0", obs_w[0], rnd_blk2[511:480]);

        // Asynchronous reset at t = 30
        blk_in = rnd_blk;
        blk_valid = 1'b1;
        @(posedge clk); #1;
        blk_valid = 1'b0;
        w_ready = 1'b1;
        cyc = 0;
        while (w_round != 6'd30 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val("reach_t30", w_round, 30);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_w_valid", w_valid, 0);
        check_val("async_blk_ready", blk_ready, 1);
        check_val("async_w_out", w_out, 0);
        check_val("async_w_round", w_round, 0);
        w_ready = 1'b0;
        @(posedge clk); #1;
        check_val("held_rst_w_valid", w_valid, 0);
        #2;
        rst_n = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        run_block({16{32'hFFFF_FFFF}}, 1'b0, 1'b0, 1'b0, '0);
        check_val("ff_W0", obs_w[0], 32'hFFFF_FFFF);

        // ROUNDS = 16 instance
        build_sched(ABC_BLK);
        blk_in = ABC_BLK;
        blk_valid16 = 1'b1;
        @(posedge clk); #1;
        blk_valid16 = 1'b0;
        w_ready16 = 1'b1;
        k = 0;
        while (k < 16 && w_valid16) begin
            check_val("r16_w_out", w_out16, exp_w[k]);
            check_val("r16_w_round", w_round16, k);
            check_val("r16_w_last", w_last16, (k == 15));
            @(posedge clk); #1;
            k++;
        end
        w_ready16 = 1'b0;
        check_val("r16_count", k, 16);
        check_val("r16_done_valid", w_valid16, 0);
        check_val("r16_done_ready", blk_ready16, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
